// File: rtl/btb_pkg.sv
// BTB controller shared definitions: set/way field layout,
// widths, default parameters and the controller state enum.
package btb_pkg;
  localparam int DEF_NUM_SETS = 8;
  localparam int INDEX_W = 3;
  localparam int TAG_W = 27;
  localparam int TGT_W = 32;
  localparam int CTR_W = 2;
  localparam int SET_W = 128;
  localparam int WAY_W = 64;
  localparam int W1_LSB = 64;
  localparam int W2_LSB = 0;
  localparam int V_BIT = 63;
  localparam int TAG_LSB = 36;
  localparam int TGT_LSB = 4;
  localparam int CTR_LSB = 2;
  localparam int IDX_LSB = 2;
  localparam int TAG_PC_LSB = 5;
  localparam logic [CTR_W-1:0] DEF_CTR_INIT = 2'b10;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_WR
  } state_t;

  function automatic logic [WAY_W-1:0] pack_way(
    input logic [TAG_W-1:0] tag,
    input logic [TGT_W-1:0] tgt,
    input logic [CTR_W-1:0] ctr
  );
    return {1'b1, tag, tgt, ctr, 2'b00};
  endfunction

  function automatic logic [CTR_W-1:0] ctr_step(
    input logic [CTR_W-1:0] c,
    input logic up
  );
    if (up) return (c == '1) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction
endpackage

// File: rtl/btb_controller_if.sv
// Lookup and update handshake bundle of the BTB controller.
// master: fetch/execute requester side; slave: the controller.
interface btb_controller_if;
  import btb_pkg::*;

  logic             lk_valid;
  logic [31:0]      lk_pc;
  logic             lk_ready;
  logic             lk_resp_valid;
  logic             lk_hit;
  logic [TGT_W-1:0] lk_target;
  logic             lk_taken;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [TGT_W-1:0] upd_target;
  logic             upd_taken;
  logic             upd_ready;
  logic             upd_done;

  modport master (
    output lk_valid, lk_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  lk_ready, lk_resp_valid, lk_hit,
    input  lk_target, lk_taken,
    input  upd_ready, upd_done
  );

  modport slave (
    input  lk_valid, lk_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output lk_ready, lk_resp_valid, lk_hit,
    output lk_target, lk_taken,
    output upd_ready, upd_done
  );
endinterface

// File: rtl/btb_way_match.sv
// Tag compare of one 2-way BTB set.
// In: set_data, tag. Out: hit1, hit2, target, ctr (hitting way).
module btb_way_match
  import btb_pkg::*;
(
  input  logic [SET_W-1:0] set_data,
  input  logic [TAG_W-1:0] tag,
  output logic             hit1,
  output logic             hit2,
  output logic [TGT_W-1:0] target,
  output logic [CTR_W-1:0] ctr
);
  logic [WAY_W-1:0] w1;
  logic [WAY_W-1:0] w2;
  logic             unused_pad;

  assign w1 = set_data[W1_LSB +: WAY_W];
  assign w2 = set_data[W2_LSB +: WAY_W];
  assign unused_pad = ^{w1[1:0], w2[1:0]};

  assign hit1 = w1[V_BIT] && (w1[TAG_LSB +: TAG_W] == tag);
  assign hit2 = w2[V_BIT] && (w2[TAG_LSB +: TAG_W] == tag);

  // way 1 wins when both ways hold the tag
  always_comb begin
    target = '0;
    ctr = '0;
    if (hit1) begin
      target = w1[TGT_LSB +: TGT_W];
      ctr = w1[CTR_LSB +: CTR_W];
    end else if (hit2) begin
      target = w2[TGT_LSB +: TGT_W];
      ctr = w2[CTR_LSB +: CTR_W];
    end
  end
endmodule

// File: rtl/btb_controller.sv
// 2-way BTB controller: arbitrates lookup vs update on the set memory.
// Ports: clk, rst (sync, active high), bus (btb_controller_if.slave).
module btb_controller
  import btb_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter logic [CTR_W-1:0] CTR_INIT = DEF_CTR_INIT
) (
  input logic            clk,
  input logic            rst,
  btb_controller_if.slave bus
);
  localparam logic [INDEX_W-1:0] LAST = INDEX_W'(NUM_SETS - 1);

  state_t state, state_n;
  logic [INDEX_W-1:0] cnt;
  logic [SET_W-1:0]   mem [NUM_SETS];
  logic [NUM_SETS-1:0] lru;
  logic [SET_W-1:0]   rd_data;
  logic               resp_q;
  logic [INDEX_W-1:0] lk_idx, upd_idx, rd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic [TGT_W-1:0]   upd_tgt;
  logic               upd_tkn;
  logic               lk_rdy, upd_rdy, done;
  logic               lk_acc, upd_acc;

  logic               l_h1, l_h2, l_hit;
  logic [TGT_W-1:0]   l_tgt;
  logic [CTR_W-1:0]   l_ctr;
  logic               u_h1, u_h2;
  logic [TGT_W-1:0]   u_tgt;
  logic [CTR_W-1:0]   u_ctr;

  logic [SET_W-1:0]   merged;
  logic [WAY_W-1:0]   new_way;
  logic               wr_en, lru_wr, lru_val, vict2;
  logic               unused_bits;

  assign unused_bits = ^{bus.lk_pc[1:0], bus.upd_pc[1:0], l_ctr[0]};

  always_comb begin
    state_n = state;
    lk_rdy = 1'b0;
    upd_rdy = 1'b0;
    done = 1'b0;
    unique case (state)
      INIT: if (cnt == LAST) state_n = IDLE;
      IDLE: begin
        upd_rdy = 1'b1;
        lk_rdy = !bus.upd_valid;
        if (bus.upd_valid) state_n = UPD_WR;
      end
      UPD_WR: begin
        done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
    // a reset cycle aborts whatever is in flight
    if (rst) begin
      lk_rdy = 1'b0;
      upd_rdy = 1'b0;
      done = 1'b0;
    end
  end

  assign bus.lk_ready = lk_rdy;
  assign bus.upd_ready = upd_rdy;
  assign bus.upd_done = done;

  assign lk_acc = bus.lk_valid && lk_rdy;
  assign upd_acc = bus.upd_valid && upd_rdy;
  assign rd_idx = upd_acc ? bus.upd_pc[IDX_LSB +: INDEX_W]
                          : bus.lk_pc[IDX_LSB +: INDEX_W];

  btb_way_match u_lk_match (
    .set_data(rd_data),
    .tag     (lk_tag),
    .hit1    (l_h1),
    .hit2    (l_h2),
    .target  (l_tgt),
    .ctr     (l_ctr)
  );

  btb_way_match u_upd_match (
    .set_data(rd_data),
    .tag     (upd_tag),
    .hit1    (u_h1),
    .hit2    (u_h2),
    .target  (u_tgt),
    .ctr     (u_ctr)
  );

  assign l_hit = l_h1 || l_h2;
  assign bus.lk_resp_valid = resp_q;
  assign bus.lk_hit = resp_q && l_hit;
  assign bus.lk_target = resp_q ? l_tgt : '0;
  assign bus.lk_taken = resp_q && l_hit && l_ctr[1];

  // lru=1 marks way 2 as least recently used
  always_comb begin
    merged = rd_data;
    new_way = '0;
    wr_en = 1'b0;
    lru_wr = 1'b0;
    lru_val = lru[upd_idx];
    vict2 = rd_data[W1_LSB + V_BIT] &&
            (!rd_data[W2_LSB + V_BIT] || lru[upd_idx]);
    if (u_h1 || u_h2) begin
      new_way = pack_way(upd_tag, upd_tkn ? upd_tgt : u_tgt,
                         ctr_step(u_ctr, upd_tkn));
      wr_en = 1'b1;
      lru_wr = 1'b1;
      lru_val = u_h1;
      if (u_h1) merged[W1_LSB +: WAY_W] = new_way;
      else merged[W2_LSB +: WAY_W] = new_way;
    end else if (upd_tkn) begin
      new_way = pack_way(upd_tag, upd_tgt, CTR_INIT);
      wr_en = 1'b1;
      lru_wr = 1'b1;
      lru_val = !vict2;
      if (vict2) merged[W2_LSB +: WAY_W] = new_way;
      else merged[W1_LSB +: WAY_W] = new_way;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      resp_q <= 1'b0;
    end else begin
      state <= state_n;
      resp_q <= lk_acc;
      if (state == INIT) begin
        mem[cnt] <= '0;
        lru[cnt] <= 1'b0;
        cnt <= cnt + 1'b1;
      end
      if (lk_acc || upd_acc) rd_data <= mem[rd_idx];
      if (lk_acc) begin
        lk_idx <= bus.lk_pc[IDX_LSB +: INDEX_W];
        lk_tag <= bus.lk_pc[TAG_PC_LSB +: TAG_W];
      end
      if (upd_acc) begin
        upd_idx <= bus.upd_pc[IDX_LSB +: INDEX_W];
        upd_tag <= bus.upd_pc[TAG_PC_LSB +: TAG_W];
        upd_tgt <= bus.upd_target;
        upd_tkn <= bus.upd_taken;
      end
      if (resp_q && l_hit) lru[lk_idx] <= l_h1;
      // placed last so an update's LRU value wins on the same set
      if (state == UPD_WR) begin
        if (wr_en) mem[upd_idx] <= merged;
        if (lru_wr) lru[upd_idx] <= lru_val;
      end
    end
  end
endmodule

// File: doc/btb_controller.md
# btb_controller

Sequencing and arbitration controller for the 2-way set-associative branch target buffer. It owns the single-port BTB set memory (NUM_SETS × 128-bit sets) and shares it between the fetch-stage lookup port and the execute-stage update port. Update is higher priority and performs a read-modify-write: 2-bit counter training, target refresh, allocation and LRU replacement. A reset-time sweep invalidates every set.

## Interface
- NUM_SETS, 8: number of sets; only 8 is legal (index = pc[4:2], tag = pc[31:5], 27 bits)
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken)

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lk_valid  in  1  fetch lookup request
- lk_pc  in  32  fetch PC
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready
- lk_resp_valid  out  1  one-cycle pulse, response for the lookup accepted the previous cycle
- lk_hit  out  1  tag hit in either way
- lk_target  out  32  predicted target
- lk_taken  out  1  counter MSB of the hitting way; 0 on miss
- upd_valid  in  1  resolved-branch update request
- upd_pc  in  32  branch PC
- upd_target  in  32  resolved target
- upd_taken  in  1  actual outcome
- upd_ready  out  1  update accepted when upd_valid && upd_ready
- upd_done  out  1  one-cycle pulse in the write cycle of an update

## Operation
- Set layout:
  - Way 1: [127] valid, [126:100] tag, [99:68] target, [67:66] ctr, [65:64] zero.
  - Way 2: [63] valid, [62:36] tag, [35:4] target, [3:2] ctr, [1:0] zero.
- LRU: one flop per set, held outside the memory. lru=0 means way 1 is least recently used.
- Memory: synchronous read (data next cycle), one access per cycle (read or write).
- States:
  - INIT: a counter sweeps sets 0..NUM_SETS-1, writing all-zero, one set per cycle, and clears LRU. lk_ready and upd_ready are 0. After the last set the FSM goes to IDLE.
  - IDLE: upd_ready=1, lk_ready=!upd_valid.
    - Accepted update: read the upd_pc set, latch the request, go to UPD_WR.
    - Accepted lookup: read the lk_pc set, latch the tag, stay in IDLE. Back-to-back lookups run at one per cycle.
  - UPD_WR: read data is present. Build the merged set, write it if the write is enabled, pulse upd_done, return to IDLE. Both ready outputs are 0.
- Lookup decode (cycle after accept):
  - hitN = validN && tag match.
  - Way 1 has priority when both ways hit.
  - lk_target = hitting way's target; 0 on miss.
  - On hit, LRU of that set points to the other way.
- Update merge:
  - Hit, way h (way 1 priority): ctr saturating +1 if taken, -1 if not (3 stays 3, 0 stays 0). Target replaced only if taken. LRU points to the other way.
  - Miss and taken: victim is the first invalid way (way 1 first), otherwise the LRU way. Write valid=1, tag, upd_target, ctr=CTR_INIT. LRU points to the other way. The non-victim way is written back unchanged.
  - Miss and not taken: no memory write; upd_done still pulses.
- Same-cycle conflict: a lookup-hit LRU update and an update-write LRU change to the same set → the update's value wins.

## Timing
- Reset values: lk_ready=0, upd_ready=0, lk_resp_valid=0, lk_hit=0, lk_target=0, lk_taken=0, upd_done=0. FSM enters INIT with counter 0.
- rst deasserted at cycle 0 → INIT cycles 0..7 → IDLE and upd_ready=1 at cycle 8.
- Lookup latency: accept at T → response at T+1. Response outputs are registered and valid only while lk_resp_valid=1. Otherwise lk_hit, lk_target and lk_taken are 0.
- Update: accept at T → write and upd_done at T+1 → IDLE at T+2. Peak rate is one update per 2 cycles, so lookups get at least every other cycle.
- A lookup accepted at T whose response is at T+1 while an update is accepted at T+1: the response uses the T read and is unaffected.
- A lookup accepted at T+2 after an update write at T+1 to the same set sees the new data (no bypass needed).
- rst in any state (including mid-INIT or UPD_WR) aborts the operation; no write occurs that cycle. The pending update is dropped without upd_done, and the sweep restarts from set 0.

## Structure
- btb_pkg:
  - Field bit positions and widths (TAG_W=27, TGT_W=32, CTR_W=2, SET_W=128, INDEX_W=3).
  - Way-slice helper constants and CTR_INIT.
  - State enum {INIT, IDLE, UPD_WR}.
- One sub-module, btb_way_match: combinational set + tag → hit1, hit2, target, ctr. It is instantiated twice, once for the lookup response and once for the update merge.
- Memory is modeled as a flop array inside btb_controller.

## Test plan
- Reset, then lookup pc=0x0000_1004 at cycle 8 → lk_ready=0 during cycles 0-7; response at 9 has lk_hit=0, lk_taken=0, lk_target=0.
- Update pc=0x0000_1004, target=0x2000, taken → upd_done one cycle after accept. Lookup same pc → hit=1, target=0x2000, taken=1 (ctr=2'b10).
- Three not-taken updates on that entry → ctr 10→01→00→00 (saturation). Lookup → hit=1, taken=0. A fourth update with taken=1 → ctr=01.
- Taken updates to pc 0x1004, 0x2004, 0x3004 (same set 1):
  - Way 1 gets 0x1004, way 2 gets 0x2004.
  - A lookup hit on 0x1004 sets LRU to way 2.
  - 0x3004 then evicts 0x2004; 0x1004 still hits.
- Miss update with taken=0 → memory unchanged; upd_done still pulses.
- upd_valid and lk_valid both high in IDLE → update accepted, lk_ready=0 for 2 cycles. Assert rst during UPD_WR → no upd_done, INIT restarts, and all lookups miss afterward.
